// File: rtl/aes_pkg.sv
// Shared AES definitions: field constants, FSM encoding, MixColumns coefficients
// and byte/column helpers. Multiplies by constants go through xtime chains only.
package aes_pkg;

  localparam logic [7:0] AES_POLY = 8'h1B;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam logic [7:0] FWD_COEF [4] = '{8'd2, 8'd3, 8'd1, 8'd1};
  localparam logic [7:0] INV_COEF [4] = '{8'd14, 8'd11, 8'd13, 8'd9};

  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? AES_POLY : 8'h00);
  endfunction

  // Only the coefficients used by MixColumns/InvMixColumns are supported.
  function automatic logic [7:0] gf_mul_const(input logic [7:0] a, input logic [7:0] k);
    logic [7:0] x2, x4, x8, res;
    x2 = xtime(a);
    x4 = xtime(x2);
    x8 = xtime(x4);
    case (k)
      8'd2:    res = x2;
      8'd3:    res = x2 ^ a;
      8'd9:    res = x8 ^ a;
      8'd11:   res = x8 ^ x2 ^ a;
      8'd13:   res = x8 ^ x4 ^ a;
      8'd14:   res = x8 ^ x4 ^ x2;
      default: res = a;
    endcase
    return res;
  endfunction

  // Row 0 of a column sits in the most significant byte.
  function automatic logic [7:0] get_byte(input logic [31:0] col, input logic [1:0] r);
    logic [7:0] res;
    case (r)
      2'd0:    res = col[31:24];
      2'd1:    res = col[23:16];
      2'd2:    res = col[15:8];
      default: res = col[7:0];
    endcase
    return res;
  endfunction

  // Column 0 of the state sits in the most significant word.
  function automatic logic [31:0] get_col(input logic [127:0] st, input logic [1:0] c);
    logic [31:0] res;
    case (c)
      2'd0:    res = st[127:96];
      2'd1:    res = st[95:64];
      2'd2:    res = st[63:32];
      default: res = st[31:0];
    endcase
    return res;
  endfunction

  function automatic logic [127:0] set_col(input logic [127:0] st, input logic [1:0] c,
                                           input logic [31:0] col);
    logic [127:0] res;
    res = st;
    case (c)
      2'd0:    res[127:96] = col;
      2'd1:    res[95:64]  = col;
      2'd2:    res[63:32]  = col;
      default: res[31:0]   = col;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/gf_mix_column.sv
// Combinational (Inv)MixColumns on one 32-bit column. With INV_SUPPORT=0 the
// inverse coefficients fold away and only the forward network remains.
module gf_mix_column
  import aes_pkg::*;
#(
  parameter bit INV_SUPPORT = 1'b1
) (
  input  logic [31:0] col_i,
  input  logic        inv_i,
  output logic [31:0] col_o
);

  logic [7:0] o [4];
  logic [7:0] coef;

  always_comb begin
    coef = 8'd0;
    for (int r = 0; r < 4; r++) begin
      o[r] = 8'h00;
      for (int k = 0; k < 4; k++) begin
        coef = (INV_SUPPORT && inv_i) ? INV_COEF[k] : FWD_COEF[k];
        o[r] = o[r] ^ gf_mul_const(get_byte(col_i, 2'(r + k)), coef);
      end
    end
    col_o = {o[0], o[1], o[2], o[3]};
  end

endmodule

// File: rtl/mix_columns_seq.sv
// Sequential MixColumns/InvMixColumns: one column per cycle over a 128-bit buffer,
// valid/ready on both sides.
//   state | meaning
//   IDLE  | ready for a block (in_ready high once out of reset)
//   CALC  | buffer column col replaced by its mix each cycle, 4 cycles
//   DONE  | result held on out_state until out_ready
module mix_columns_seq
  import aes_pkg::*;
#(
  parameter bit INV_SUPPORT = 1'b1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] in_state,
  input  logic         in_inv,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] out_state,
  output logic         busy
);

  state_e         state_q, state_d;
  logic [1:0]     col_q, col_d;
  logic [127:0]   buf_q, buf_d;
  logic           inv_q, inv_d;
  logic           live_q;
  logic [31:0]    col_cur, col_mix;

  assign col_cur = get_col(buf_q, col_q);

  gf_mix_column #(.INV_SUPPORT(INV_SUPPORT)) u_mix (
    .col_i (col_cur),
    .inv_i (inv_q),
    .col_o (col_mix)
  );

  // live_q keeps in_ready low while reset is held and for no longer.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      live_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      live_q  <= 1'b1;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (in_valid && in_ready) state_d = CALC;
      CALC:    if (col_q == 2'd3) state_d = DONE;
      DONE:    if (out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    in_ready  = live_q && (state_q == IDLE);
    out_valid = (state_q == DONE);
    busy      = (state_q == CALC) || (state_q == DONE);
  end

  always_comb begin
    buf_d = buf_q;
    col_d = col_q;
    inv_d = inv_q;
    if (state_q == IDLE && in_valid && in_ready) begin
      buf_d = in_state;
      inv_d = INV_SUPPORT ? in_inv : 1'b0;
      col_d = 2'd0;
    end else if (state_q == CALC) begin
      buf_d = set_col(buf_q, col_q, col_mix);
      col_d = col_q + 2'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      buf_q <= '0;
      col_q <= 2'd0;
      inv_q <= 1'b0;
    end else begin
      buf_q <= buf_d;
      col_q <= col_d;
      inv_q <= inv_d;
    end
  end

  assign out_state = buf_q;

endmodule

// File: tb/tb_mix_columns_seq.sv
// Directed bench for mix_columns_seq: FIPS-197 vectors both directions, backpressure,
// back-to-back blocks, reset during CALC, and a forward-only build.
module tb_mix_columns_seq;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid, in_inv, out_ready;
  logic [127:0] in_state;
  logic         in_ready, out_valid, busy;
  logic [127:0] out_state;

  logic         in_valid2, in_inv2, out_ready2;
  logic [127:0] in_state2;
  logic         in_ready2, out_valid2, busy2;
  logic [127:0] out_state2;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mix_columns_seq #(.INV_SUPPORT(1'b1)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_state(in_state), .in_inv(in_inv),
    .out_valid(out_valid), .out_ready(out_ready), .out_state(out_state), .busy(busy)
  );

  mix_columns_seq #(.INV_SUPPORT(1'b0)) dut_fwd (
    .clk(clk), .rst(rst),
    .in_valid(in_valid2), .in_ready(in_ready2), .in_state(in_state2), .in_inv(in_inv2),
    .out_valid(out_valid2), .out_ready(out_ready2), .out_state(out_state2), .busy(busy2)
  );

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Accept one block, toggle in_inv during CALC, check latency and result, then drain.
  task automatic run_block(input string tag, input logic [127:0] st, input logic inv,
                           input logic [127:0] exp);
    int n;
    int lat;
    in_state = st;
    in_inv   = inv;
    in_valid = 1'b1;
    n = 0;
    while (!in_ready && n < 20) begin tick(); n++; end
    check({tag, "_ready"}, in_ready, 1'b1);
    tick();
    in_valid = 1'b0;
    in_inv   = ~inv;
    in_state = {4{32'hdeadbeef}};
    lat = 0;
    while (!out_valid && lat < 20) begin tick(); lat++; end
    check({tag, "_lat"}, lat, 4);
    check(tag, out_state, exp);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check({tag, "_drop"}, out_valid, 1'b0);
  endtask

  localparam logic [127:0] FWD_IN  = 128'hdb135345_f20a225c_01010101_c6c6c6c6;
  localparam logic [127:0] FWD_OUT = 128'h8e4da1bc_9fdc589d_01010101_c6c6c6c6;
  localparam logic [127:0] BLK_A   = 128'h2d26314c_db135345_01010101_c6c6c6c6;
  localparam logic [127:0] RES_A   = 128'h4d7ebdf8_8e4da1bc_01010101_c6c6c6c6;
  localparam logic [127:0] BLK_B   = 128'hd4d4d4d5_f20a225c_c6c6c6c6_01010101;
  localparam logic [127:0] RES_B   = 128'hd5d5d7d6_9fdc589d_c6c6c6c6_01010101;

  initial begin
    logic [127:0] held;
    logic [127:0] got_data [2];
    int           got_cyc  [2];
    int           n_out, nb_acc, n;
    logic         acc_pend;

    rst = 1'b1;
    in_valid = 1'b0; in_inv = 1'b0; out_ready = 1'b0; in_state = '0;
    in_valid2 = 1'b0; in_inv2 = 1'b0; out_ready2 = 1'b0; in_state2 = '0;
    tick();
    check("rst_in_ready", in_ready, 1'b0);
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_out_state", out_state, '0);
    check("rst_busy", busy, 1'b0);
    rst = 1'b0;
    tick();
    check("post_rst_ready", in_ready, 1'b1);

    run_block("fwd_fips", FWD_IN, 1'b0, FWD_OUT);
    run_block("inv_fips", FWD_OUT, 1'b1, FWD_IN);
    run_block("inv_col0", 128'hd5d5d7d6_01010101_c6c6c6c6_8e4da1bc, 1'b1,
              128'hd4d4d4d5_01010101_c6c6c6c6_db135345);

    // Backpressure: hold out_ready low for 10 cycles once the result is up.
    in_state = BLK_A; in_inv = 1'b0; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    n = 0;
    while (!out_valid && n < 20) begin tick(); n++; end
    check("bp_valid", out_valid, 1'b1);
    held = out_state;
    check("bp_data", held, RES_A);
    for (int i = 0; i < 10; i++) begin
      tick();
      check("bp_hold_valid", out_valid, 1'b1);
      check("bp_hold_data", out_state, held);
      check("bp_hold_ready", in_ready, 1'b0);
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check("bp_release_valid", out_valid, 1'b0);
    check("bp_release_ready", in_ready, 1'b1);

    // Back-to-back with in_valid held high and out_ready always high.
    out_ready = 1'b1;
    in_state = BLK_A; in_inv = 1'b0; in_valid = 1'b1;
    tick();
    in_state = BLK_B;
    n_out = 0; nb_acc = 0; acc_pend = 1'b0;
    got_data[0] = '0; got_data[1] = '0; got_cyc[0] = 0; got_cyc[1] = 0;
    for (int c = 1; c <= 16; c++) begin
      tick();
      if (acc_pend) begin
        acc_pend = 1'b0;
        nb_acc++;
        in_valid = 1'b0;
      end
      if (out_valid) begin
        if (n_out < 2) begin
          got_data[n_out] = out_state;
          got_cyc[n_out]  = c;
        end
        n_out++;
      end
      if (in_valid && in_ready) acc_pend = 1'b1;
    end
    out_ready = 1'b0;
    check("b2b_count", n_out, 2);
    check("b2b_accepts", nb_acc, 1);
    check("b2b_first", got_data[0], RES_A);
    check("b2b_second", got_data[1], RES_B);
    check("b2b_first_cyc", got_cyc[0], 4);
    check("b2b_spacing", got_cyc[1] - got_cyc[0], 6);

    // Reset while col==2 in CALC.
    in_state = FWD_IN; in_inv = 1'b0; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tick();
    tick();
    check("mid_busy", busy, 1'b1);
    rst = 1'b1;
    #1;
    check("mid_rst_valid", out_valid, 1'b0);
    check("mid_rst_state", out_state, '0);
    check("mid_rst_busy", busy, 1'b0);
    check("mid_rst_ready", in_ready, 1'b0);
    tick();
    rst = 1'b0;
    tick();
    check("mid_post_ready", in_ready, 1'b1);
    check("mid_post_valid", out_valid, 1'b0);
    run_block("after_rst", FWD_IN, 1'b0, FWD_OUT);

    // Forward-only build must ignore in_inv.
    in_state2 = FWD_IN; in_inv2 = 1'b1; in_valid2 = 1'b1;
    n = 0;
    while (!in_ready2 && n < 20) begin tick(); n++; end
    tick();
    in_valid2 = 1'b0;
    n = 0;
    while (!out_valid2 && n < 20) begin tick(); n++; end
    check("fwdonly_lat", n, 4);
    check("fwdonly_data", out_state2, FWD_OUT);
    out_ready2 = 1'b1;
    tick();
    out_ready2 = 1'b0;
    check("fwdonly_drop", out_valid2, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
